// File: rtl/ahb_pkg.sv
// Purpose : shared AHB-Lite encodings and controller state encoding.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings; anything above WORD is unsupported by this slave
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Words per populated RAM bank
    localparam int BANK_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_RSTALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_lane_decode.sv
// Purpose : map transfer size and low address bits to a byte-lane mask plus misalignment flag.
// Latency : combinational, zero cycles.
// Backpressure: none; pure decode.
// Ports   : size (HSIZE), addr_lo (HADDR[1:0]) -> mask (byte lanes), misaligned.
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       misaligned
);

    always_comb begin
        mask       = 4'b0000;
        misaligned = 1'b0;
        case (size)
            HSIZE_BYTE: begin
                mask = 4'b0001 << addr_lo;
            end
            HSIZE_HALF: begin
                mask       = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
            end
            HSIZE_WORD: begin
                mask       = 4'b1111;
                misaligned = |addr_lo;
            end
            // Oversized transfers are rejected by the caller; no lanes here.
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_ram_ctrl.sv
// Purpose : AHB-Lite slave driving a single-port synchronous RAM_4Kx32 (byte writes, sync reads, errors).
// Latency : zero-wait writes and reads; one wait state for a read directly after a write; 2-cycle ERROR.
// Backpressure: HREADYOUT low only in the read-after-write stall and the first ERROR cycle.
// Ports   : AHB-Lite slave (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY -> HREADYOUT/HRESP/HRDATA),
//           RAM port (RAM_EN/RAM_WE/RAM_A/RAM_Di out, RAM_Do in).
module ahb_ram_ctrl
    import ahb_pkg::*;
#(
    parameter int BLOCKS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        RAM_EN,
    output logic [3:0]  RAM_WE,
    output logic [12:0] RAM_A,
    output logic [31:0] RAM_Di,
    input  logic [31:0] RAM_Do
);

    localparam logic [13:0] WORD_LIMIT = 14'(BLOCKS * BANK_WORDS);

    state_t      state_q, state_d;
    logic [12:0] addr_q;
    logic [3:0]  mask_q;

    logic [12:0] word_idx;
    logic [3:0]  lane_mask;
    logic        misaligned;
    logic        accept;
    logic        take;
    logic        illegal;

    ahb_lane_decode u_lane_decode (
        .size       (HSIZE),
        .addr_lo    (HADDR[1:0]),
        .mask       (lane_mask),
        .misaligned (misaligned)
    );

    assign word_idx = HADDR[14:2];
    assign accept   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    // A new address phase is never taken while this slave itself is holding the bus low.
    assign take     = accept & (state_q != ST_RSTALL) & (state_q != ST_ERR1);
    assign illegal  = (HSIZE > HSIZE_WORD) | misaligned
                    | ({1'b0, word_idx} >= WORD_LIMIT) | (|HADDR[31:15]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            // A write's own address is consumed at this edge, so the same register
            // can hold the address of a read accepted during its data phase.
            if (take) begin
                addr_q <= word_idx;
                mask_q <= lane_mask;
            end
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_RSTALL: state_d = ST_RDATA;
            ST_ERR1:   state_d = ST_ERR2;
            default: begin
                if (take) begin
                    if (illegal)
                        state_d = ST_ERR1;
                    else if (HWRITE)
                        state_d = ST_WDATA;
                    else if (state_q == ST_WDATA)
                        state_d = ST_RSTALL;
                    else
                        state_d = ST_RDATA;
                end
            end
        endcase
    end

    // Port priority: write data phase, then stalled read, then a fresh read address phase.
    always_comb begin
        RAM_EN = 1'b0;
        RAM_WE = 4'b0000;
        RAM_A  = addr_q;
        RAM_Di = HWDATA;
        if (!RST) begin
            if (state_q == ST_WDATA) begin
                RAM_EN = 1'b1;
                RAM_WE = mask_q;
            end else if (state_q == ST_RSTALL) begin
                RAM_EN = 1'b1;
            end else if (take && !illegal && !HWRITE) begin
                // Issue straight from the bus so the RAM samples at the accepting edge.
                RAM_EN = 1'b1;
                RAM_A  = word_idx;
            end
        end
    end

    always_comb begin
        HREADYOUT = (state_q != ST_RSTALL) && (state_q != ST_ERR1);
        HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = (state_q == ST_RDATA) ? RAM_Do : 32'h0;
    end

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// Purpose : directed self-checking bench for ahb_ram_ctrl with a behavioural RAM_4Kx32 model.
// Latency : n/a.
// Backpressure: HREADY is looped back from HREADYOUT, as for a lone slave on the matrix.
module tb_ahb_ram_ctrl;
    import ahb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        RAM_EN;
    logic [3:0]  RAM_WE;
    logic [12:0] RAM_A;
    logic [31:0] RAM_Di;
    logic [31:0] RAM_Do;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:8191];
    logic [7:0]  bytes_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] pre_v   [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

    assign HREADY = HREADYOUT;

    always #5 CLK = ~CLK;

    ahb_ram_ctrl #(.BLOCKS(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .RAM_EN    (RAM_EN),
        .RAM_WE    (RAM_WE),
        .RAM_A     (RAM_A),
        .RAM_Di    (RAM_Di),
        .RAM_Do    (RAM_Do)
    );

    // Synchronous single-port RAM: byte-lane writes, read data one cycle after the sampling edge.
    always @(posedge CLK) begin
        if (RAM_EN) begin
            for (int b = 0; b < 4; b++)
                if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
            if (RAM_WE == 4'b0000) RAM_Do <= mem[RAM_A];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
    endtask

    task automatic idle();
        drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST    = 1'b1;
        HWDATA = 32'h0;
        idle();

        // Reset values
        mid();
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(HRESP),     32'd0);
        chk("rst_hrdata",    HRDATA,         32'h0);
        chk("rst_ram_en",    32'(RAM_EN),    32'd0);
        chk("rst_ram_we",    32'(RAM_WE),    32'd0);
        step();
        RST = 1'b0;

        // 1: word write then back-to-back read of the same address
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h100);
        mid();
        chk("t1_waddr_ram_en", 32'(RAM_EN), 32'd0);
        step();
        HWDATA = 32'hDEAD_BEEF;
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h100);
        mid();
        chk("t1_wdata_we",   32'(RAM_WE),    32'hF);
        chk("t1_wdata_a",    32'(RAM_A),     32'h40);
        chk("t1_wdata_di",   RAM_Di,         32'hDEAD_BEEF);
        chk("t1_wdata_rdy",  32'(HREADYOUT), 32'd1);
        step();
        idle();
        mid();
        chk("t1_stall_rdy",    32'(HREADYOUT), 32'd0);
        chk("t1_stall_en",     32'(RAM_EN),    32'd1);
        chk("t1_stall_we",     32'(RAM_WE),    32'd0);
        chk("t1_stall_hrdata", HRDATA,         32'h0);
        step();
        mid();
        chk("t1_rdata",     HRDATA,         32'hDEAD_BEEF);
        chk("t1_rdata_rdy", 32'(HREADYOUT), 32'd1);
        step();

        // 2: four byte writes then a word read
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h200);
        step();
        for (int i = 0; i < 4; i++) begin
            HWDATA = {4{bytes_v[i]}};
            if (i < 3) drive(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h201 + 32'(i));
            else       drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h200);
            mid();
            chk("t2_byte_we", 32'(RAM_WE), 32'(1 << i));
            step();
        end
        idle();
        mid();
        chk("t2_stall_rdy", 32'(HREADYOUT), 32'd0);
        step();
        mid();
        chk("t2_rdata", HRDATA, 32'h4433_2211);
        step();

        // 3: preload four words over the bus, then stream four reads
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(4 * i));
            else       idle();
            if (i > 0) HWDATA = pre_v[i-1];
            step();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'(4 * i));
            else       idle();
            mid();
            chk("t3_stream_rdy", 32'(HREADYOUT), 32'd1);
            if (i < 4) begin
                chk("t3_stream_en", 32'(RAM_EN), 32'd1);
                chk("t3_stream_a",  32'(RAM_A),  32'(i));
            end
            if (i > 0) chk("t3_stream_data", HRDATA, pre_v[i-1]);
            step();
        end

        // 4: out-of-range word read, then a misaligned half read issued in ERR2
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h4000);
        mid();
        chk("t4_range_addr_en", 32'(RAM_EN), 32'd0);
        step();
        idle();
        mid();
        chk("t4_err1_rdy",  32'(HREADYOUT), 32'd0);
        chk("t4_err1_resp", 32'(HRESP),     32'd1);
        chk("t4_err1_en",   32'(RAM_EN),    32'd0);
        step();
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h3);
        mid();
        chk("t4_err2_rdy",  32'(HREADYOUT), 32'd1);
        chk("t4_err2_resp", 32'(HRESP),     32'd1);
        chk("t4_err2_en",   32'(RAM_EN),    32'd0);
        step();
        idle();
        mid();
        chk("t4_half_err1_rdy",  32'(HREADYOUT), 32'd0);
        chk("t4_half_err1_resp", 32'(HRESP),     32'd1);
        chk("t4_half_err1_en",   32'(RAM_EN),    32'd0);
        step();
        mid();
        chk("t4_half_err2_rdy",  32'(HREADYOUT), 32'd1);
        chk("t4_half_err2_resp", 32'(HRESP),     32'd1);
        step();
        mid();
        chk("t4_after_resp", 32'(HRESP), 32'd0);
        step();

        // 5: IDLE and BUSY while selected are zero-wait OKAY with no RAM access
        drive(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h10);
        mid();
        chk("t5_idle_rdy",  32'(HREADYOUT), 32'd1);
        chk("t5_idle_resp", 32'(HRESP),     32'd0);
        chk("t5_idle_en",   32'(RAM_EN),    32'd0);
        step();
        drive(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10);
        mid();
        chk("t5_after_idle_en", 32'(RAM_EN), 32'd0);
        step();
        mid();
        chk("t5_busy_rdy",  32'(HREADYOUT), 32'd1);
        chk("t5_busy_resp", 32'(HRESP),     32'd0);
        chk("t5_busy_en",   32'(RAM_EN),    32'd0);
        chk("t5_busy_we",   32'(RAM_WE),    32'd0);
        step();
        idle();

        // 6: reset during a write data phase drops the write
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h300);
        step();
        HWDATA = 32'h1234_5678;
        idle();
        step();
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h300);
        step();
        HWDATA = 32'hCAFE_F00D;
        idle();
        #2;
        RST = 1'b1;
        #1;
        chk("t6_rst_we",     32'(RAM_WE),    32'd0);
        chk("t6_rst_en",     32'(RAM_EN),    32'd0);
        chk("t6_rst_rdy",    32'(HREADYOUT), 32'd1);
        chk("t6_rst_resp",   32'(HRESP),     32'd0);
        chk("t6_rst_hrdata", HRDATA,         32'h0);
        step();
        RST = 1'b0;
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h300);
        step();
        idle();
        mid();
        chk("t6_old_data", HRDATA, 32'h1234_5678);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
